// File: rtl/taus_pkg.sv
// Shared types and constants for the Tausworthe URNG controller:
// FSM states, seed minima, generator latency and the seed legality check.
package taus_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        PRIME = 3'd2,
        WARM  = 3'd3,
        RUN   = 3'd4,
        ERR   = 3'd5
    } state_t;

    localparam logic [31:0] S0_MIN   = 32'd1;
    localparam logic [31:0] S1_MIN   = 32'd7;
    localparam logic [31:0] S2_MIN   = 32'd15;
    localparam int          URNG_LAT = 2;

    // Each component needs enough non-zero upper bits to avoid a degenerate stream.
    function automatic logic seeds_legal(input logic [31:0] s0,
                                         input logic [31:0] s1,
                                         input logic [31:0] s2);
        return (s0 > S0_MIN) && (s1 > S1_MIN) && (s2 > S2_MIN);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational winner search starting at a registered
// pointer; the pointer advances past the winner only when a grant is taken.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_en,
    input  logic [NREQ-1:0] i_req,
    output logic [NREQ-1:0] o_gnt,
    output logic            o_any
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = PW + 1;

    logic [PW-1:0] r_ptr;
    logic [SW-1:0] w_sum [NREQ];
    logic [PW-1:0] w_idx [NREQ];
    logic [NREQ-1:0] w_rot;
    logic [PW-1:0] w_win;
    logic          w_any;

    // w_rot[k] is the request k positions after the pointer.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
            assign w_sum[gi] = {1'b0, r_ptr} + SW'(gi);
            assign w_idx[gi] = (w_sum[gi] >= SW'(NREQ)) ? PW'(w_sum[gi] - SW'(NREQ))
                                                         : PW'(w_sum[gi]);
            assign w_rot[gi] = i_req[w_idx[gi]];
            assign o_gnt[gi] = w_any && (w_win == PW'(gi));
        end
    endgenerate

    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_any = 1'b1;
                w_win = w_idx[k];
            end
        end
    end

    assign o_any = w_any;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_en && w_any) begin
            r_ptr <= (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
        end
    end

endmodule

// File: rtl/taus_urng_ctrl.sv
// Seeds, primes and shares one Tausworthe URNG among NREQ round-robin consumers.
// Define TAUS_SAMPLE_CNT_EN to build the granted-sample counter on sample_cnt.
module taus_urng_ctrl
    import taus_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int WARMUP = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            seed_we,
    input  logic [1:0]      seed_addr,
    input  logic [31:0]     seed_wdata,
    input  logic            start,
    input  logic            stop,
    output logic            urng_reset,
    output logic [31:0]     urng_s0,
    output logic [31:0]     urng_s1,
    output logic [31:0]     urng_s2,
    input  logic [31:0]     urng_r,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [31:0]     sample,
    output logic            busy,
    output logic            running,
    output logic            seed_err,
    output logic [31:0]     sample_cnt
);

    localparam logic [7:0] PRIME_LAST = 8'(URNG_LAT - 1);
    localparam logic [7:0] WARM_LAST  = (WARMUP > 0) ? 8'(WARMUP - 1) : 8'd0;

    state_t          r_state, w_state_next;
    logic [7:0]      r_cnt, w_cnt_next;
    logic            r_urng_reset;
    logic [31:0]     r_s0, r_s1, r_s2;
    logic [NREQ-1:0] r_gnt;
    logic [31:0]     r_sample;
    logic            r_seed_err;
    logic            w_seed_ok;
    logic            w_seed_wr_ok;
    logic            w_arb_en;
    logic            w_any;
    logic [NREQ-1:0] w_win_onehot;

    assign w_seed_ok    = seeds_legal(r_s0, r_s1, r_s2);
    assign w_seed_wr_ok = (r_state == IDLE) || (r_state == ERR);
    // A stop in RUN must already suppress the grant of that cycle.
    assign w_arb_en     = (r_state == RUN) && !stop;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_arb_en),
        .i_req (req),
        .o_gnt (w_win_onehot),
        .o_any (w_any)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE:  if (start) w_state_next = CHECK;
            CHECK: begin
                w_cnt_next   = '0;
                w_state_next = w_seed_ok ? PRIME : ERR;
            end
            PRIME: begin
                if (r_cnt == PRIME_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = (WARMUP == 0) ? RUN : WARM;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            WARM: begin
                if (r_cnt == WARM_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = RUN;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            RUN:   w_state_next = RUN;
            ERR:   if (start) w_state_next = CHECK;
            default: w_state_next = IDLE;
        endcase
        if (stop && (r_state != IDLE)) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_urng_reset <= 1'b1;
            r_s0         <= '0;
            r_s1         <= '0;
            r_s2         <= '0;
            r_gnt        <= '0;
            r_sample     <= '0;
            r_seed_err   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_urng_reset <= !((w_state_next == PRIME) || (w_state_next == WARM) ||
                              (w_state_next == RUN));
            if (seed_we && w_seed_wr_ok) begin
                case (seed_addr)
                    2'd0:    r_s0 <= seed_wdata;
                    2'd1:    r_s1 <= seed_wdata;
                    2'd2:    r_s2 <= seed_wdata;
                    default: ;
                endcase
            end
            if (r_state == CHECK) begin
                r_seed_err <= !w_seed_ok;
            end
            if (w_arb_en && w_any) begin
                r_gnt    <= w_win_onehot;
                r_sample <= urng_r;
            end else begin
                r_gnt <= '0;
            end
        end
    end

`ifdef TAUS_SAMPLE_CNT_EN
    logic [31:0] r_sample_cnt;
    logic        w_start_acc;

    assign w_start_acc = start && ((r_state == IDLE) || ((r_state == ERR) && !stop));

    always_ff @(posedge clk) begin
        if (reset || w_start_acc) begin
            r_sample_cnt <= '0;
        end else if (|r_gnt) begin
            r_sample_cnt <= r_sample_cnt + 32'd1;
        end
    end

    assign sample_cnt = r_sample_cnt;
`else
    assign sample_cnt = '0;
`endif

    assign urng_reset = r_urng_reset;
    assign urng_s0    = r_s0;
    assign urng_s1    = r_s1;
    assign urng_s2    = r_s2;
    assign gnt        = r_gnt;
    assign sample     = r_sample;
    assign busy       = (r_state != IDLE) && (r_state != ERR);
    assign running    = (r_state == RUN);
    assign seed_err   = r_seed_err;

endmodule

// File: tb/tb_taus_urng_ctrl.sv
// Bench for taus_urng_ctrl: models the generator, predicts grants/samples from
// seed words and round-robin rules, and checks every cycle of each session.
module tb_taus_urng_ctrl;

    localparam int NREQ   = 2;
    localparam int WARMUP = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            seed_we = 1'b0;
    logic [1:0]      seed_addr = 2'd0;
    logic [31:0]     seed_wdata = 32'd0;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic            urng_reset;
    logic [31:0]     urng_s0, urng_s1, urng_s2;
    logic [31:0]     urng_r = 32'd0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] gnt;
    logic [31:0]     sample;
    logic            busy, running, seed_err;
    logic [31:0]     sample_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int m_ptr    = 0;
    int g_cnt    = 0;
    logic [31:0] words [0:511];

    always #5 clk = ~clk;

    taus_urng_ctrl #(.NREQ(NREQ), .WARMUP(WARMUP)) dut (
        .clk        (clk),
        .reset      (reset),
        .seed_we    (seed_we),
        .seed_addr  (seed_addr),
        .seed_wdata (seed_wdata),
        .start      (start),
        .stop       (stop),
        .urng_reset (urng_reset),
        .urng_s0    (urng_s0),
        .urng_s1    (urng_s1),
        .urng_s2    (urng_s2),
        .urng_r     (urng_r),
        .req        (req),
        .gnt        (gnt),
        .sample     (sample),
        .busy       (busy),
        .running    (running),
        .seed_err   (seed_err),
        .sample_cnt (sample_cnt)
    );

    function automatic logic [95:0] taus_next(input logic [95:0] st);
        logic [31:0] a, b, c, t;
        a = st[95:64]; b = st[63:32]; c = st[31:0];
        t = ((a << 13) ^ a) >> 19; a = ((a & 32'hFFFF_FFFE) << 12) ^ t;
        t = ((b << 2)  ^ b) >> 25; b = ((b & 32'hFFFF_FFF8) << 4)  ^ t;
        t = ((c << 3)  ^ c) >> 11; c = ((c & 32'hFFFF_FFF0) << 17) ^ t;
        return {a, b, c};
    endfunction

    function automatic logic [31:0] taus_out(input logic [95:0] st);
        return st[95:64] ^ st[63:32] ^ st[31:0];
    endfunction

    // Generator peer: loads seeds on first unreset clock, first word one clock later.
    logic [95:0] g_st = '0;
    logic        g_loaded = 1'b0;
    always @(posedge clk) begin
        if (urng_reset) begin
            g_loaded <= 1'b0;
        end else if (!g_loaded) begin
            g_st     <= {urng_s0, urng_s1, urng_s2};
            g_loaded <= 1'b1;
        end else begin
            g_st   <= taus_next(g_st);
            urng_r <= taus_out(taus_next(g_st));
        end
    end

    function automatic logic [31:0] exp_cnt_val(input int n);
`ifdef TAUS_SAMPLE_CNT_EN
        return 32'(n);
`else
        return 32'(0 * n);
`endif
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic write_seed(input logic [1:0] addr, input logic [31:0] data);
        seed_we = 1'b1; seed_addr = addr; seed_wdata = data;
        @(posedge clk); #1;
        seed_we = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_urng_reset", 32'(urng_reset), 32'd1);
        check("rst_s0", urng_s0, 32'd0);
        check("rst_s1", urng_s1, 32'd0);
        check("rst_s2", urng_s2, 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_sample", sample, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_seed_err", 32'(seed_err), 32'd0);
        check("rst_cnt", sample_cnt, 32'd0);
    endtask

    task automatic do_stop(input logic also_start, input logic exp_err);
        stop = 1'b1; start = also_start;
        @(posedge clk); #1;
        stop = 1'b0; start = 1'b0;
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_running", 32'(running), 32'd0);
        check("stop_gnt", 32'(gnt), 32'd0);
        check("stop_urng_reset", 32'(urng_reset), 32'd1);
        check("stop_seed_err", 32'(seed_err), 32'(exp_err));
        check("stop_cnt", sample_cnt, exp_cnt_val(g_cnt));
        $display("stop start=%0d busy=%0d gnt=%b urng_reset=%0d", also_start, busy, gnt, urng_reset);
    endtask

    task automatic session(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input int nrun, input bit rnd, input logic [NREQ-1:0] fix);
        logic            legal;
        logic [95:0]     st;
        logic [NREQ-1:0] exp_gnt;
        logic [31:0]     exp_sample;
        int              cl, w, ngr;
        legal = (a > 32'd1) && (b > 32'd7) && (c > 32'd15);
        write_seed(2'd0, a);
        write_seed(2'd1, b);
        write_seed(2'd2, c);
        check("seed_s0", urng_s0, a);
        check("seed_s1", urng_s1, b);
        check("seed_s2", urng_s2, c);
        st = {a, b, c};
        for (int k = 1; k <= WARMUP + nrun + 2; k++) begin
            st = taus_next(st);
            words[k] = taus_out(st);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        g_cnt = 0;
        check("check_busy", 32'(busy), 32'd1);
        check("check_urng_reset", 32'(urng_reset), 32'd1);
        check("check_cnt_clr", sample_cnt, exp_cnt_val(0));
        @(posedge clk); #1;
        if (!legal) begin
            check("err_seed_err", 32'(seed_err), 32'd1);
            check("err_busy", 32'(busy), 32'd0);
            for (int i = 0; i < 4; i++) begin
                req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
                @(posedge clk); #1;
                check("err_gnt", 32'(gnt), 32'd0);
                check("err_urng_reset", 32'(urng_reset), 32'd1);
                check("err_running", 32'(running), 32'd0);
            end
            req = '0;
            $display("session seeds=%h/%h/%h illegal seed_err=%0d", a, b, c, seed_err);
            return;
        end
        check("prime_seed_err", 32'(seed_err), 32'd0);
        exp_gnt = '0; exp_sample = '0; ngr = 0;
        cl = 4 + WARMUP + nrun;
        for (int cy = 2; cy <= cl; cy++) begin
            if (cy > 2) begin @(posedge clk); #1; end
            check("running", 32'(running), 32'(cy >= 4 + WARMUP));
            check("urng_reset_low", 32'(urng_reset), 32'd0);
            check("gnt", 32'(gnt), 32'(exp_gnt));
            if (exp_gnt != '0) check("sample", sample, exp_sample);
            check("cnt", sample_cnt, exp_cnt_val(g_cnt));
            if (exp_gnt != '0) g_cnt++;
            if (cy >= 4 + WARMUP && cy < cl)
                req = rnd ? NREQ'($urandom_range(0, (1 << NREQ) - 1)) : fix;
            else if (rnd && cy < 4 + WARMUP)
                req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            else
                req = '0;
            exp_gnt = '0;
            if (cy >= 4 + WARMUP) begin
                w = rr_pick(req, m_ptr);
                if (w >= 0) begin
                    exp_gnt    = NREQ'(1) << w;
                    exp_sample = words[cy - 3];
                    m_ptr      = (w + 1) % NREQ;
                    ngr++;
                end
            end
        end
        @(posedge clk); #1;
        check("tail_gnt", 32'(gnt), 32'd0);
        check("tail_cnt", sample_cnt, exp_cnt_val(g_cnt));
        $display("session seeds=%h/%h/%h run=%0d grants=%0d cnt=%0d", a, b, c, nrun, ngr, sample_cnt);
    endtask

    initial begin
        logic [31:0] ra, rb, rc;
        reset = 1'b1;
        repeat (3) @(posedge clk); #1;
        check_reset_values();
        reset = 1'b0;

        session(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_F0F0, 8, 1'b0, 2'b01);
        write_seed(2'd0, 32'hDEAD_BEEF);
        check("seed_wr_in_run", urng_s0, 32'h1234_5678);
        do_stop(1'b1, 1'b0);

        session(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_F0F0, 20, 1'b0, 2'b11);
        do_stop(1'b0, 1'b0);

        ra = $urandom | 32'h10; rb = $urandom | 32'h10; rc = $urandom | 32'h10;
        session(ra, rb, rc, 60, 1'b1, 2'b00);
        do_stop(1'b0, 1'b0);

        session(ra, 32'd7, rc, 0, 1'b0, 2'b00);
        session(ra, 32'd8, rc, 12, 1'b1, 2'b00);
        do_stop(1'b0, 1'b0);
        session(32'd1, rb, rc, 0, 1'b0, 2'b00);
        do_stop(1'b0, 1'b1);
        session(32'd2, rb, 32'd15, 0, 1'b0, 2'b00);
        session(32'd2, 32'd8, 32'd16, 6, 1'b1, 2'b00);
        do_stop(1'b0, 1'b0);

        ra = $urandom | 32'h10; rb = $urandom | 32'h10; rc = $urandom | 32'h10;
        session(ra, rb, rc, 100, 1'b0, 2'b10);
        check("cnt_100", sample_cnt, exp_cnt_val(100));
        do_stop(1'b0, 1'b0);

        write_seed(2'd0, ra); write_seed(2'd1, rb); write_seed(2'd2, rc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk); #1;
        check("warm_busy", 32'(busy), 32'd1);
        check("warm_running", 32'(running), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_ptr = 0; g_cnt = 0;
        check_reset_values();
        $display("reset in WARM seeds=%h/%h/%h busy=%0d", urng_s0, urng_s1, urng_s2, busy);

        session(rc, ra, rb, 30, 1'b1, 2'b00);
        do_stop(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/taus_urng_ctrl.md
Name: taus_urng_ctrl

Overview:
- Controller that seeds, primes and shares one three-component Tausworthe uniform generator (`tausworthe`) among NREQ consumers, e.g. the Box-Muller u0/u1 paths of the AWGN core.
- Owns the generator's reset and seed inputs: validates seeds, releases the generator, discards a warm-up run, then hands one 32-bit sample per cycle to a round-robin-selected requester.

Parameters:
- NREQ, 2, number of requesters (2..8).
- WARMUP, 16, number of generator outputs discarded after seeding (0..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- seed_we  in  1  seed register write strobe
- seed_addr  in  2  0=s0, 1=s1, 2=s2, 3=ignored
- seed_wdata  in  32  seed write data
- start  in  1  pulse: validate seeds and begin sequencing
- stop  in  1  pulse: halt and hold generator in reset
- urng_reset  out  1  drives generator reset
- urng_s0, urng_s1, urng_s2  out  32 each  seed registers to generator
- urng_r  in  32  generator output r
- req  in  NREQ  per-requester sample request (level)
- gnt  out  NREQ  one-hot grant, qualifies sample
- sample  out  32  granted sample
- busy  out  1  state != IDLE/ERR
- running  out  1  state == RUN
- seed_err  out  1  sticky: last start found an illegal seed
- sample_cnt  out  32  granted-sample count (see Optional Feature)

Behaviour:
- Reset: state=IDLE; urng_reset=1; seeds=32'h0; gnt=0; sample=0; seed_err=0; rr pointer=0; sample_cnt=0.
- Seed writes are accepted only in IDLE/ERR; ignored otherwise.
- Generator timing: first clock with urng_reset=0 loads the seeds; the first valid urng_r appears 2 clocks after urng_reset falls; one new value every clock after that.
- FSM:
  - IDLE: urng_reset=1. On start → CHECK.
  - CHECK (1 cycle): legal iff s0>1, s1>7, s2>15 (unsigned). Legal → clear seed_err, → PRIME. Illegal → set seed_err, → ERR.
  - PRIME: urng_reset=0; count 2 cycles → WARM (or → RUN if WARMUP=0).
  - WARM: discard urng_r for exactly WARMUP cycles → RUN.
  - RUN: urng_reset=0; every cycle sample a generator word.
  - ERR: urng_reset=1. On start → CHECK. Seed writes are allowed.
- stop in any state except IDLE: → IDLE next cycle, urng_reset=1, gnt cleared. stop has priority over start in the same cycle.
- Arbitration (RUN only): round-robin over req, starting at the rr pointer.
  - Registered outputs: gnt<=onehot winner, sample<=urng_r.
  - Latency 1 clock from req to gnt/sample. Each urng_r is granted at most once; words with no req are dropped.
  - After a grant, pointer <= winner+1 mod NREQ. With no req, the pointer holds.
  - A requester dropping req after the grant is irrelevant; the grant stands.
- gnt is 0 in every state other than RUN, including the first cycle after leaving RUN.
- Reset mid-operation aborts immediately to the reset values, including the seeds.

Optional Feature:
- TAUS_SAMPLE_CNT_EN defined: sample_cnt increments on every cycle with |gnt. It wraps at 2^32 and clears on reset and on each start.
- Undefined: no counter logic; sample_cnt is tied to 0. The port is kept so the interface does not change.

Decomposition:
- Package taus_pkg holds:
  - state enum (IDLE, CHECK, PRIME, WARM, RUN, ERR)
  - seed minima constants S0_MIN=1, S1_MIN=7, S2_MIN=15
  - URNG_LAT=2
- One sub-module: rr_arbiter (NREQ-wide, combinational winner plus pointer register).
- The generator is instantiated at the next level up, not inside this block.

Test Plan:
- Write seeds 32'h1234_5678/32'h9ABC_DEF0/32'h0F0F_F0F0, start, req=2'b01 → urng_reset falls 2 cycles after start; first gnt exactly 2+2+16 cycles after the CHECK cycle; sample equals the 17th generator output of a reference model.
- req=2'b11 held in RUN → gnt alternates 01,10,01,...; consecutive samples are consecutive generator words with no repeats.
- s1=32'd7, start → seed_err=1, state ERR, urng_reset stays 1, gnt never asserted. Rewrite s1=8, start → seed_err=0, run proceeds.
- stop and start asserted together in RUN → IDLE next cycle, gnt=0, urng_reset=1.
- reset pulsed during WARM → all outputs at reset values next cycle; seeds read 0.
- TAUS_SAMPLE_CNT_EN, 100 cycles with req=2'b10 → sample_cnt=100. Without the macro → sample_cnt=0.
